// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage: word width, reset/bubble
// values and instruction field positions.
package fetch_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int RT_LSB     = 16;
  localparam int RT_W       = 5;
  localparam int IMM_W      = 16;
  localparam int JIDX_W     = 26;

endpackage

// File: rtl/fetch_stage_next_pc.sv
// Next-PC selection for the fetch stage: hold on stall, otherwise
// JR > J > branch > sequential, with redirects only from a valid ID slot.
module next_pc
  import fetch_stage_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              id_valid,
  input  logic [WORD_W-1:0] rs_data,
  input  logic [WORD_W-1:0] id_instr,
  input  logic [WORD_W-1:0] id_pc_plus4,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] pc_next,
  output logic              redirect
);

  logic [WORD_W-1:0] jr_target;
  logic [WORD_W-1:0] j_target;
  logic [WORD_W-1:0] br_target;

  always_comb begin
    pc_plus4  = pc + 32'd4;
    jr_target = {rs_data[WORD_W-1:2], 2'b00};
    j_target  = {id_pc_plus4[WORD_W-1:28], id_instr[JIDX_W-1:0], 2'b00};
    br_target = id_pc_plus4 +
                {{(WORD_W-IMM_W-2){id_instr[IMM_W-1]}}, id_instr[IMM_W-1:0], 2'b00};

    // A request against a bubble is stale; the controller re-issues it later.
    redirect = id_valid & ~stall & (jump_reg | jump | branch);

    pc_next = pc_plus4;
    if (stall) begin
      pc_next = pc;
    end else if (id_valid && jump_reg) begin
      pc_next = jr_target;
    end else if (id_valid && jump) begin
      pc_next = j_target;
    end else if (id_valid && branch) begin
      pc_next = br_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a count
// of valid instructions captured. Instruction memory is read combinationally.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Stall,
  input  logic                Branch,
  input  logic                Jump,
  input  logic                JumpReg,
  input  logic [WORD_W-1:0]   RsData,
  input  logic [WORD_W-1:0]   IMemData,
  output logic [WORD_W-1:0]   IMemAddr,
  output logic [WORD_W-1:0]   IF_ID_Instr,
  output logic [WORD_W-1:0]   IF_ID_PCPlus4,
  output logic                IF_ID_Valid,
  output logic [OPCODE_W-1:0] OPCode,
  output logic [FUNCT_W-1:0]  Function,
  output logic [RT_W-1:0]     TargetReg,
  output logic [WORD_W-1:0]   FetchCount
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] count_q, count_d;

  logic [WORD_W-1:0] seq_pc_plus4;
  logic [WORD_W-1:0] sel_pc;
  logic              redirect;

  next_pc u_next_pc (
    .pc          (pc_q),
    .stall       (Stall),
    .branch      (Branch),
    .jump        (Jump),
    .jump_reg    (JumpReg),
    .id_valid    (valid_q),
    .rs_data     (RsData),
    .id_instr    (instr_q),
    .id_pc_plus4 (pc_plus4_q),
    .pc_plus4    (seq_pc_plus4),
    .pc_next     (sel_pc),
    .redirect    (redirect)
  );

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (!Stall) begin
      pc_d = sel_pc;
      // The word fetched this cycle is on the wrong path after a redirect.
      if (redirect) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d    = IMemData;
        pc_plus4_d = seq_pc_plus4;
        valid_d    = 1'b1;
        count_d    = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign IMemAddr      = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pc_plus4_q;
  assign IF_ID_Valid   = valid_q;
  assign FetchCount    = count_q;
  assign OPCode        = instr_q[OPCODE_LSB +: OPCODE_W];
  assign Function      = instr_q[FUNCT_LSB +: FUNCT_W];
  assign TargetReg     = instr_q[RT_LSB +: RT_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized control
// inputs, checked against an instruction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        jump_reg;
  logic [31:0] rs_data;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  target_reg;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, one entry per architectural quantity.
  logic [31:0] m_pc, m_instr, m_pcp4, m_count;
  logic        m_valid;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk           (clk),
    .Rst           (rst_n),
    .Stall         (stall),
    .Branch        (branch),
    .Jump          (jump),
    .JumpReg       (jump_reg),
    .RsData        (rs_data),
    .IMemData      (imem_data),
    .IMemAddr      (imem_addr),
    .IF_ID_Instr   (if_id_instr),
    .IF_ID_PCPlus4 (if_id_pc_plus4),
    .IF_ID_Valid   (if_id_valid),
    .OPCode        (opcode),
    .Function      (funct),
    .TargetReg     (target_reg),
    .FetchCount    (fetch_count)
  );

  assign imem_data = mem[imem_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_instr = 32'h0000_0000;
    m_pcp4  = 32'h0000_0000;
    m_valid = 1'b0;
    m_count = 32'h0000_0000;
  endtask

  // One clock edge of the fetch rules, evaluated on the current inputs.
  task automatic model_edge();
    logic [31:0] target;
    int          offset;
    if (stall) return;
    if (m_valid && (jump_reg || jump || branch)) begin
      offset = int'($signed(m_instr[15:0])) * 4;
      if (jump_reg)  target = rs_data - (rs_data % 4);
      else if (jump) target = (m_pcp4 & 32'hF000_0000) + (m_instr & 32'h03FF_FFFF) * 4;
      else           target = m_pcp4 + 32'(offset);
      m_pc    = target;
      m_instr = 32'h0000_0000;
      m_valid = 1'b0;
    end else begin
      m_instr = mem[m_pc[9:2]];
      m_pcp4  = m_pc + 4;
      m_pc    = m_pc + 4;
      m_valid = 1'b1;
      m_count = m_count + 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_addr"},   imem_addr, m_pc);
    chk({tag, "_instr"},  if_id_instr, m_instr);
    chk({tag, "_valid"},  32'(if_id_valid), 32'(m_valid));
    chk({tag, "_count"},  fetch_count, m_count);
    chk({tag, "_opcode"}, 32'(opcode), 32'(m_instr >> 26));
    chk({tag, "_funct"},  32'(funct), m_instr % 64);
    chk({tag, "_rt"},     32'(target_reg), (m_instr >> 16) % 32);
    if (m_valid) chk({tag, "_pcp4"}, if_id_pc_plus4, m_pcp4);
  endtask

  task automatic do_edge(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    rs_data = 32'h0;
    for (int k = 0; k < 256; k++) mem[k] = 32'h2008_0000 + 32'(k);

    // Reset values
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    chk("reset_pcp4", if_id_pc_plus4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 4; i++) do_edge("seq");
    chk("seq_count4", fetch_count, 32'd4);
    chk("seq_last_instr", if_id_instr, 32'h2008_0003);

    // Taken branch with a beq at PC 8
    #2 rst_n = 1'b0;
    model_reset();
    mem[2] = 32'h1000_FFFE;
    #1;
    check_state("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_edge("pre_br");
    chk("pre_br_instr", if_id_instr, 32'h1000_FFFE);
    branch = 1'b1;
    do_edge("branch");
    chk("branch_pc", imem_addr, 32'h0000_0004);
    chk("branch_count", fetch_count, 32'd3);
    do_edge("bubble_ignore");
    chk("bubble_pc", imem_addr, 32'h0000_0008);
    branch = 1'b0;

    // Redirect priority
    jump = 1'b1; branch = 1'b1; jump_reg = 1'b1; rs_data = 32'h0000_0103;
    do_edge("prio");
    chk("prio_pc", imem_addr, 32'h0000_0100);
    jump = 1'b0; branch = 1'b0; jump_reg = 1'b0;
    do_edge("post_prio");

    // Stall holds a pending jump
    stall = 1'b1; jump = 1'b1;
    do_edge("stall1");
    do_edge("stall2");
    chk("stall_pc", imem_addr, 32'h0000_0104);
    chk("stall_instr", if_id_instr, 32'h2008_0040);
    stall = 1'b0;
    do_edge("unstall");
    chk("unstall_pc", imem_addr, 32'h0020_0100);
    jump = 1'b0;

    // PC wrap
    do_edge("pre_wrap");
    jump_reg = 1'b1; rs_data = 32'hFFFF_FFFF;
    do_edge("jr_top");
    chk("jr_top_pc", imem_addr, 32'hFFFF_FFFC);
    jump_reg = 1'b0;
    do_edge("wrap");
    chk("wrap_pc", imem_addr, 32'h0000_0000);
    chk("wrap_pcp4", if_id_pc_plus4, 32'h0000_0000);

    // Asynchronous reset while a jump is requested
    jump = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    chk("async_rst_pcp4", if_id_pc_plus4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_edge("first_after_rst");
    chk("first_after_rst_pc", imem_addr, 32'h0000_0004);
    jump = 1'b0;

    // Randomized control
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 4) == 0);
      branch   = ($urandom_range(0, 3) == 0);
      jump     = ($urandom_range(0, 5) == 0);
      jump_reg = ($urandom_range(0, 7) == 0);
      rs_data  = $urandom;
      do_edge("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
